// File: rtl/ram_march_bist_if.sv
// Signal bundle between the march BIST sequencer, its test controller and the RAM it exercises.
// The master side is the sequencer; the slave side is the controller/RAM environment.
interface ram_march_bist_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  // Handshake: start is a level sampled only while idle. busy is high for the whole
  // run, done pulses for one cycle at the end, and pass/fail_*/err_cnt hold until the next start.
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [2:0]            fail_elem;
  logic [15:0]           err_cnt;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_q;

  modport master (
    input  start, ram_q,
    output busy, done, pass, fail_addr, fail_elem, err_cnt,
    output ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output start, ram_q,
    input  busy, done, pass, fail_addr, fail_elem, err_cnt,
    input  ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_march_bist.sv
// March C- self-test sequencer for a single-port RAM with a registered 1-cycle read.
// Elements M1..M5 spend two cycles per address: A issues the read, B compares ram_q and writes.
module ram_march_bist #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 128,
  parameter logic [DATA_WIDTH-1:0] BG_PATTERN = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_march_bist_if.master bus,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_M0   = 4'd1,
    S_M1   = 4'd2,
    S_M2   = 4'd3,
    S_M3   = 4'd4,
    S_M4   = 4'd5,
    S_M5   = 4'd6,
    S_DONE = 4'd7
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] PAT_Z = BG_PATTERN;
  localparam logic [DATA_WIDTH-1:0] PAT_O = ~BG_PATTERN;

  state_t                state, state_n;
  logic                  phase_b, phase_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;

  logic                  busy, we, descending, elem_last, compare, mismatch, start_run;
  logic [DATA_WIDTH-1:0] wdata, exp_rd;
  logic [2:0]            elem;

  logic                  pass_r;
  logic [ADDR_WIDTH-1:0] fail_addr_r;
  logic [2:0]            fail_elem_r;
  logic [15:0]           err_cnt_r;

  // Per-element decode: bus drive, expected read value and traversal direction.
  always_comb begin
    busy       = 1'b0;
    we         = 1'b0;
    wdata      = '0;
    exp_rd     = PAT_Z;
    elem       = 3'd0;
    descending = 1'b0;
    unique case (state)
      S_M0: begin
        busy  = 1'b1;
        we    = 1'b1;
        wdata = PAT_Z;
      end
      S_M1: begin
        busy   = 1'b1;
        elem   = 3'd1;
        we     = phase_b;
        wdata  = phase_b ? PAT_O : '0;
        exp_rd = PAT_Z;
      end
      S_M2: begin
        busy   = 1'b1;
        elem   = 3'd2;
        we     = phase_b;
        wdata  = phase_b ? PAT_Z : '0;
        exp_rd = PAT_O;
      end
      S_M3: begin
        busy       = 1'b1;
        elem       = 3'd3;
        descending = 1'b1;
        we         = phase_b;
        wdata      = phase_b ? PAT_O : '0;
        exp_rd     = PAT_Z;
      end
      S_M4: begin
        busy       = 1'b1;
        elem       = 3'd4;
        descending = 1'b1;
        we         = phase_b;
        wdata      = phase_b ? PAT_Z : '0;
        exp_rd     = PAT_O;
      end
      S_M5: begin
        busy   = 1'b1;
        elem   = 3'd5;
        exp_rd = PAT_Z;
      end
      default: ;
    endcase
  end

  assign elem_last = descending ? (addr == '0) : (addr == LAST);
  assign compare   = busy && (state != S_M0) && phase_b;
  assign mismatch  = compare && (bus.ram_q != exp_rd);
  assign start_run = (state == S_IDLE) && bus.start;

  always_comb begin
    state_n = state;
    phase_n = phase_b;
    addr_n  = addr;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_M0;
          phase_n = 1'b0;
          addr_n  = '0;
        end
      end
      S_M0: begin
        if (elem_last) begin
          state_n = S_M1;
          addr_n  = '0;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: begin
        if (!phase_b) begin
          phase_n = 1'b1;
        end else begin
          phase_n = 1'b0;
          if (!elem_last) begin
            addr_n = descending ? addr - 1'b1 : addr + 1'b1;
          end else begin
            // Each element starts at the end its own direction begins from.
            unique case (state)
              S_M1: begin state_n = S_M2;   addr_n = '0;   end
              S_M2: begin state_n = S_M3;   addr_n = LAST; end
              S_M3: begin state_n = S_M4;   addr_n = LAST; end
              S_M4: begin state_n = S_M5;   addr_n = '0;   end
              default: begin state_n = S_DONE; addr_n = '0; end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      phase_b <= 1'b0;
      addr    <= '0;
    end else begin
      state   <= state_n;
      phase_b <= phase_n;
      addr    <= addr_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_r      <= 1'b0;
      fail_addr_r <= '0;
      fail_elem_r <= '0;
      err_cnt_r   <= '0;
    end else if (start_run) begin
      pass_r      <= 1'b0;
      fail_addr_r <= '0;
      fail_elem_r <= '0;
      err_cnt_r   <= '0;
    end else begin
      if (mismatch) begin
        if (err_cnt_r == 16'h0000) begin
          fail_addr_r <= addr;
          fail_elem_r <= elem;
        end
        if (err_cnt_r != 16'hFFFF) err_cnt_r <= err_cnt_r + 16'd1;
      end
      // The final compare may itself mismatch, so fold it in before pass is published.
      if ((state == S_M5) && phase_b && elem_last) pass_r <= (err_cnt_r == 16'h0000) && !mismatch;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = (state == S_DONE);
  assign bus.pass      = pass_r;
  assign bus.fail_addr = fail_addr_r;
  assign bus.fail_elem = fail_elem_r;
  assign bus.err_cnt   = err_cnt_r;
  assign bus.ram_we    = we;
  assign bus.ram_addr  = busy ? addr : '0;
  assign bus.ram_wdata = wdata;
  assign state_dbg     = state;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: two instances (128 words / bg 00, 100 words / bg A5), each on a RAM
// model with an injectable read-path stuck-at fault, against a march-level reference model.
module tb_ram_march_bist;
  localparam int         AW      = 7;
  localparam int         DW      = 8;
  localparam int         DEPTH_A = 128;
  localparam int         DEPTH_B = 100;
  localparam logic [7:0] BG_A    = 8'h00;
  localparam logic [7:0] BG_B    = 8'hA5;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
  ram_march_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();
  logic [3:0] dbg_a, dbg_b, dbg_idle_a, dbg_idle_b;

  ram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH_A), .BG_PATTERN(BG_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master), .state_dbg(dbg_a)
  );
  ram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH_B), .BG_PATTERN(BG_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.master), .state_dbg(dbg_b)
  );

  logic       start_r = 1'b0;
  logic       sel_b   = 1'b0;
  int         f_addr  = -1;
  logic [7:0] f_sa1   = 8'h00;
  logic [7:0] f_sa0   = 8'h00;
  assign ifa.start = start_r & ~sel_b;
  assign ifb.start = start_r & sel_b;

  // RAM models: registered read, read-path stuck-at fault on instance A only
  logic [7:0] mem_a [128];
  logic [7:0] mem_b [128];
  logic [7:0] q_a, q_b;
  logic [6:0] ra_a;
  always @(posedge clk) begin
    if (ifa.ram_we) mem_a[ifa.ram_addr] <= ifa.ram_wdata;
    q_a  <= mem_a[ifa.ram_addr];
    ra_a <= ifa.ram_addr;
    if (ifb.ram_we) mem_b[ifb.ram_addr] <= ifb.ram_wdata;
    q_b  <= mem_b[ifb.ram_addr];
  end
  assign ifa.ram_q = (int'(ra_a) == f_addr) ? ((q_a | f_sa1) & ~f_sa0) : q_a;
  assign ifb.ram_q = q_b;

  logic        busy_s, done_s, pass_s;
  logic [15:0] err_s;
  logic [6:0]  faddr_s;
  logic [2:0]  felem_s;
  always_comb begin
    if (sel_b) begin
      busy_s = ifb.busy; done_s = ifb.done; pass_s = ifb.pass;
      err_s = ifb.err_cnt; faddr_s = ifb.fail_addr; felem_s = ifb.fail_elem;
    end else begin
      busy_s = ifa.busy; done_s = ifa.done; pass_s = ifa.pass;
      err_s = ifa.err_cnt; faddr_s = ifa.fail_addr; felem_s = ifa.fail_elem;
    end
  end

  // scoreboard: expected {we, addr, wdata} per busy cycle
  logic [15:0] exp_qa[$];
  logic [15:0] exp_qb[$];
  int          mon_err = 0;
  int          n_vec   = 0;
  int          n_bad   = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.busy) begin
        if (exp_qa.size() == 0) mon_err++;
        else if ({ifa.ram_we, ifa.ram_addr, ifa.ram_wdata} != exp_qa.pop_front()) mon_err++;
      end else if ({ifa.ram_we, ifa.ram_addr, ifa.ram_wdata} != 16'h0000) mon_err++;
      if (ifb.busy) begin
        if (exp_qb.size() == 0) mon_err++;
        else if ({ifb.ram_we, ifb.ram_addr, ifb.ram_wdata} != exp_qb.pop_front()) mon_err++;
      end else if ({ifb.ram_we, ifb.ram_addr, ifb.ram_wdata} != 16'h0000) mon_err++;
    end
  end

  task automatic check(input string name, input longint act, input longint expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: walk the March C- read elements at word level and record mismatches.
  task automatic ref_model(input int depth, input logic [7:0] bg, input int fa,
                           input logic [7:0] sa1, input logic [7:0] sa0,
                           output int errs, output int xa, output int xe);
    errs = 0; xa = 0; xe = 0;
    for (int e = 1; e <= 5; e++) begin
      for (int i = 0; i < depth; i++) begin
        int         a;
        logic [7:0] want, seen;
        a    = (e == 3 || e == 4) ? depth - 1 - i : i;
        want = (e == 2 || e == 4) ? ~bg : bg;
        seen = (a == fa) ? ((want | sa1) & ~sa0) : want;
        if (seen != want) begin
          if (errs == 0) begin xa = a; xe = e; end
          errs++;
        end
      end
    end
  endtask

  task automatic build_exp(input bit b, input int depth, input logic [7:0] bg);
    logic [15:0] w;
    for (int i = 0; i < depth; i++) begin
      w = {1'b1, 7'(i), bg};
      if (b) exp_qb.push_back(w); else exp_qa.push_back(w);
    end
    for (int e = 1; e <= 5; e++) begin
      for (int i = 0; i < depth; i++) begin
        int         a;
        logic [7:0] wv;
        a  = (e == 3 || e == 4) ? depth - 1 - i : i;
        wv = (e % 2 == 1) ? ~bg : bg;
        w  = {1'b0, 7'(a), 8'h00};
        if (b) exp_qb.push_back(w); else exp_qa.push_back(w);
        w  = (e == 5) ? {1'b0, 7'(a), 8'h00} : {1'b1, 7'(a), wv};
        if (b) exp_qb.push_back(w); else exp_qa.push_back(w);
      end
    end
  endtask

  task automatic start_run(input bit b, input bit hold);
    sel_b = b;
    build_exp(b, b ? DEPTH_B : DEPTH_A, b ? BG_B : BG_A);
    mon_err = 0;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk); #1;
    check("start_busy", busy_s, 1);
    check("start_clear", {pass_s, err_s, faddr_s, felem_s}, 0);
    check("fsm_left_idle", (b ? dbg_b : dbg_a) != (b ? dbg_idle_b : dbg_idle_a), 1);
    if (!hold) start_r = 1'b0;
  endtask

  task automatic finish_run(input int depth, input int poke);
    int cycles;
    cycles = 1;
    while (busy_s && cycles <= 11 * depth + 5) begin
      @(posedge clk); #1;
      if (busy_s) cycles++;
      if (poke > 0) start_r = (cycles == poke);
    end
    if (poke > 0) start_r = 1'b0;
    check("busy_cycles", cycles, 11 * depth);
    check("done_pulse", {busy_s, done_s}, 2'b01);
    @(posedge clk); #1;
    check("done_one_cycle", {busy_s, done_s}, 2'b00);
  endtask

  task automatic check_result(input bit p, input int errs, input int xa, input int xe);
    check("pass", pass_s, p);
    check("err_cnt", err_s, errs);
    check("fail_addr", faddr_s, xa);
    check("fail_elem", felem_s, xe);
  endtask

  task automatic check_bus();
    check("bus_sequence", mon_err, 0);
    check("bus_seq_left", exp_qa.size() + exp_qb.size(), 0);
  endtask

  typedef struct {
    int         fa;
    logic [7:0] sa1;
    logic [7:0] sa0;
    bit         p;
    int         errs;
    int         xa;
    int         xe;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{-1,  8'h00, 8'h00, 1'b1, 0, 0,   0};  // good RAM
    vecs[1] = '{5,   8'h01, 8'h00, 1'b0, 3, 5,   1};  // bit0 stuck-1: M1, M3, M5
    vecs[2] = '{0,   8'h00, 8'h80, 1'b0, 2, 0,   2};  // bit7 stuck-0: M2, M4
    vecs[3] = '{127, 8'h08, 8'h00, 1'b0, 3, 127, 1};  // last address
    vecs[4] = '{64,  8'h80, 8'h01, 1'b0, 5, 64,  1};  // both polarities
    vecs[5] = '{-1,  8'h00, 8'h00, 1'b1, 0, 0,   0};  // good run after faulty run

    for (int i = 0; i < 128; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end

    // reset state
    #12;
    check("reset_a", {ifa.busy, ifa.done, ifa.pass, ifa.err_cnt, ifa.fail_addr, ifa.fail_elem,
                      ifa.ram_we, ifa.ram_addr, ifa.ram_wdata}, 0);
    check("reset_b", {ifb.busy, ifb.done, ifb.pass, ifb.err_cnt, ifb.fail_addr, ifb.fail_elem,
                      ifb.ram_we, ifb.ram_addr, ifb.ram_wdata}, 0);
    dbg_idle_a = dbg_a;
    dbg_idle_b = dbg_b;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // table-driven fault runs
    for (int v = 0; v < 6; v++) begin
      f_addr = vecs[v].fa; f_sa1 = vecs[v].sa1; f_sa0 = vecs[v].sa0;
      start_run(1'b0, 1'b0);
      finish_run(DEPTH_A, 0);
      check_result(vecs[v].p, vecs[v].errs, vecs[v].xa, vecs[v].xe);
      check_bus();
    end

    // start held high: one run, idle cycle, then exactly one more run
    f_addr = -1;
    build_exp(1'b0, DEPTH_A, BG_A);
    start_run(1'b0, 1'b1);
    finish_run(DEPTH_A, 0);
    check("held_pass1", pass_s, 1);
    @(posedge clk); #1;
    check("held_restart", busy_s, 1);
    start_r = 1'b0;
    finish_run(DEPTH_A, 0);
    check_result(1'b1, 0, 0, 0);
    check_bus();

    // asynchronous reset mid-run
    f_addr = 5; f_sa1 = 8'h01; f_sa0 = 8'h00;
    start_run(1'b0, 1'b0);
    repeat (499) @(posedge clk);
    #1;
    check("pre_reset_err", ifa.err_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {ifa.busy, ifa.done, ifa.pass, ifa.err_cnt, ifa.fail_addr, ifa.fail_elem,
                          ifa.ram_we, ifa.ram_addr, ifa.ram_wdata}, 0);
    repeat (2) @(posedge clk);
    exp_qa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    f_addr = -1;
    start_run(1'b0, 1'b0);
    finish_run(DEPTH_A, 0);
    check_result(1'b1, 0, 0, 0);
    check_bus();

    // randomized faults, with a stray start pulse mid-run
    for (int r = 0; r < 6; r++) begin
      int errs, xa, xe;
      f_addr = $urandom_range(0, DEPTH_A - 1);
      f_sa1  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'h00;
      f_sa0  = 8'($urandom_range(0, 255)) & ~f_sa1;
      ref_model(DEPTH_A, BG_A, f_addr, f_sa1, f_sa0, errs, xa, xe);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      start_run(1'b0, 1'b0);
      finish_run(DEPTH_A, $urandom_range(2, 1000));
      check_result(errs == 0, errs, xa, xe);
      check_bus();
    end

    // DEPTH=100, BG=A5 instance
    f_addr = -1;
    start_run(1'b1, 1'b0);
    finish_run(DEPTH_B, 0);
    check_result(1'b1, 0, 0, 0);
    check_bus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
